// File: rtl/de0_lt24_sopc_cpu_div_cell.sv
// de0_lt24_sopc_cpu_div_cell: fixed-latency radix-2 restoring divider, signed or unsigned
module de0_lt24_sopc_cpu_div_cell #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A_div_src1,
  input  logic [WIDTH-1:0] A_div_src2,
  input  logic             A_div_signed,
  input  logic             A_div_start,
  output logic             A_div_busy,
  output logic             A_div_done,
  output logic [WIDTH-1:0] A_div_quotient,
  output logic [WIDTH-1:0] A_div_remainder
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;
  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   p;
  logic [WIDTH-1:0] q, d;
  logic             sgn, neg_q, neg_r, div0;
  logic [WIDTH:0]   p_sh;
  logic             ge;
  always_comb begin
    p_sh = {p[WIDTH-1:0], q[WIDTH-1]};
    ge   = p_sh >= {1'b0, d};
  end
  // raw operands are parked in q/d at accept; PREP turns them into magnitudes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      cnt             <= '0;
      p               <= '0;
      q               <= '0;
      d               <= '0;
      sgn             <= 1'b0;
      neg_q           <= 1'b0;
      neg_r           <= 1'b0;
      div0            <= 1'b0;
      A_div_busy      <= 1'b0;
      A_div_done      <= 1'b0;
      A_div_quotient  <= '0;
      A_div_remainder <= '0;
    end else begin
      A_div_done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          state <= A_div_start ? PREP : IDLE;
          if (A_div_start) begin
            q          <= A_div_src1;
            d          <= A_div_src2;
            sgn        <= A_div_signed;
            A_div_busy <= 1'b1;
          end
        end
        PREP: begin
          neg_q <= sgn & (q[WIDTH-1] ^ d[WIDTH-1]);
          neg_r <= sgn & q[WIDTH-1];
          q     <= (sgn & q[WIDTH-1]) ? -q : q;
          d     <= (sgn & d[WIDTH-1]) ? -d : d;
          div0  <= d == '0;
          p     <= '0;
          cnt   <= '0;
          state <= ITER;
        end
        ITER: begin
          p     <= ge ? p_sh - {1'b0, d} : p_sh;
          q     <= {q[WIDTH-2:0], ge};
          cnt   <= cnt + 1'b1;
          state <= (cnt == CW'(WIDTH - 1)) ? FIX : ITER;
        end
        FIX: begin
          // with a zero divisor P ends as |src1|, so the sign fix restores src1 itself
          A_div_quotient  <= div0 ? '1 : neg_q ? -q : q;
          A_div_remainder <= neg_r ? -p[WIDTH-1:0] : p[WIDTH-1:0];
          A_div_busy      <= 1'b0;
          A_div_done      <= 1'b1;
          state           <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_de0_lt24_sopc_cpu_div_cell.sv
// tb_de0_lt24_sopc_cpu_div_cell: directed-vector bench for the divider cell
module tb_de0_lt24_sopc_cpu_div_cell;
  localparam int W = 32;
  localparam int LAT = W + 2;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] src1 = '0, src2 = '0;
  logic         sgn = 1'b0, start = 1'b0;
  logic         busy, done;
  logic [W-1:0] quot, rem;
  int passed = 0, total = 0;

  de0_lt24_sopc_cpu_div_cell #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .A_div_src1(src1), .A_div_src2(src2),
    .A_div_signed(sgn), .A_div_start(start), .A_div_busy(busy),
    .A_div_done(done), .A_div_quotient(quot), .A_div_remainder(rem)
  );

  always #5 clk = ~clk;

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    @(negedge clk);
    src1 = a; src2 = b; sgn = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; src1 = $urandom; src2 = $urandom; sgn = $urandom_range(0, 1);
  endtask

  task automatic wait_done(output int edges);
    edges = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      edges++;
      if (done) break;
    end
  endtask

  task automatic test_reset;
    #1;
    total++; if ({busy, done} !== 2'b00) $display("FAIL reset_flags busy/done=%b want 00", {busy, done}); else passed++;
    total++; if (quot !== '0 || rem !== '0) $display("FAIL reset_outputs q=%h r=%h want 0/0", quot, rem); else passed++;
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_unsigned;
    int e;
    start_op(32'd100, 32'd7, 1'b0);
    total++; if (busy !== 1'b1) $display("FAIL unsigned_busy busy=%b want 1", busy); else passed++;
    wait_done(e);
    total++; if (e !== LAT) $display("FAIL unsigned_latency edges=%0d want %0d", e, LAT); else passed++;
    total++; if (quot !== 32'd14 || rem !== 32'd2) $display("FAIL unsigned_100_7 q=%h r=%h want e/2", quot, rem); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL unsigned_busy_at_done busy=%b want 0", busy); else passed++;
    @(posedge clk); #1;
    total++; if (done !== 1'b0 || quot !== 32'd14) $display("FAIL done_pulse done=%b q=%h want 0/e", done, quot); else passed++;
  endtask

  task automatic test_signed;
    int e;
    start_op(32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_done(e);
    total++; if (quot !== 32'hFFFF_FFFD || rem !== 32'hFFFF_FFFF) $display("FAIL signed_m7_2 q=%h r=%h want fffffffd/ffffffff", quot, rem); else passed++;
    start_op(32'd7, 32'hFFFF_FFFE, 1'b1);
    wait_done(e);
    total++; if (quot !== 32'hFFFF_FFFD || rem !== 32'd1) $display("FAIL signed_7_m2 q=%h r=%h want fffffffd/1", quot, rem); else passed++;
  endtask

  task automatic test_div0;
    int e;
    for (int s = 0; s < 2; s++) begin
      start_op(32'h0000_1234, 32'd0, s[0]);
      wait_done(e);
      total++; if (e !== LAT) $display("FAIL div0_latency mode=%0d edges=%0d want %0d", s, e, LAT); else passed++;
      total++; if (quot !== 32'hFFFF_FFFF || rem !== 32'h0000_1234) $display("FAIL div0 mode=%0d q=%h r=%h want ffffffff/1234", s, quot, rem); else passed++;
    end
    start_op(32'hFFFF_FFF0, 32'd0, 1'b1);
    wait_done(e);
    total++; if (quot !== 32'hFFFF_FFFF || rem !== 32'hFFFF_FFF0) $display("FAIL div0_neg q=%h r=%h want ffffffff/fffffff0", quot, rem); else passed++;
  endtask

  task automatic test_overflow;
    int e;
    start_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_done(e);
    total++; if (quot !== 32'h8000_0000 || rem !== 32'd0) $display("FAIL ovf_signed q=%h r=%h want 80000000/0", quot, rem); else passed++;
    start_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_done(e);
    total++; if (quot !== 32'd0 || rem !== 32'h8000_0000) $display("FAIL ovf_unsigned q=%h r=%h want 0/80000000", quot, rem); else passed++;
  endtask

  task automatic test_ignore_busy;
    int e;
    start_op(32'd100, 32'd7, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    src1 = 32'd5; src2 = 32'd5; sgn = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(e);
    total++; if (e + 11 !== LAT) $display("FAIL busy_start_latency edges=%0d want %0d", e + 11, LAT); else passed++;
    total++; if (quot !== 32'd14 || rem !== 32'd2) $display("FAIL busy_start_result q=%h r=%h want e/2", quot, rem); else passed++;
  endtask

  task automatic test_back_to_back;
    int e;
    start_op(32'd1000, 32'd10, 1'b0);
    wait_done(e);
    total++; if (quot !== 32'd100 || rem !== 32'd0) $display("FAIL b2b_first q=%h r=%h want 64/0", quot, rem); else passed++;
    src1 = 32'd50; src2 = 32'd8; sgn = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    total++; if (busy !== 1'b1 || done !== 1'b0) $display("FAIL b2b_accept busy/done=%b%b want 10", busy, done); else passed++;
    total++; if (quot !== 32'd100) $display("FAIL b2b_hold q=%h want 64", quot); else passed++;
    wait_done(e);
    total++; if (e !== LAT) $display("FAIL b2b_latency edges=%0d want %0d", e, LAT); else passed++;
    total++; if (quot !== 32'd6 || rem !== 32'd2) $display("FAIL b2b_second q=%h r=%h want 6/2", quot, rem); else passed++;
  endtask

  task automatic test_reset_mid;
    int e;
    logic seen;
    start_op(32'd100, 32'd7, 1'b0);
    repeat (11) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL rst_mid_flags busy/done=%b%b want 00", busy, done); else passed++;
    total++; if (quot !== '0 || rem !== '0) $display("FAIL rst_mid_outputs q=%h r=%h want 0/0", quot, rem); else passed++;
    @(negedge clk); reset = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      seen |= done | busy;
    end
    total++; if (seen !== 1'b0) $display("FAIL rst_mid_no_done activity=%b want 0", seen); else passed++;
    start_op(32'd9, 32'd3, 1'b0);
    wait_done(e);
    total++; if (quot !== 32'd3 || rem !== 32'd0 || e !== LAT) $display("FAIL rst_mid_after q=%h r=%h edges=%0d want 3/0/%0d", quot, rem, e, LAT); else passed++;
  endtask

  initial begin
    test_reset;
    test_unsigned;
    test_signed;
    test_div0;
    test_overflow;
    test_ignore_busy;
    test_back_to_back;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
